spatial_fuser: RTL and testbench

Receiving end of the spatial encoder's folded output stream. Collects the per-fold majority hypervector slices for GSR, ECG and EEG, in that order, into full-width modality buffers. Fuses the three modalities with a bitwise 3-input majority and presents one full-width fused hypervector per frame to the temporal/associative stage with a valid/ready handshake.

---
 rtl/spatial_fuser_pkg.sv | 22 ++
 rtl/spatial_fuser_fold_majority3.sv | 21 ++
 rtl/spatial_fuser.sv | 141 ++++++++++++++
 tb/tb_spatial_fuser.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatial_fuser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spatial_fuser_pkg
// Purpose  : Shared constants and the modality collection ordering used by
//            the spatial encoder output path and spatial_fuser.
// Contents : HV_DIMENSION, NUM_MODALITIES, modality_state_e
// Revision : 1.0 - initial release
// ============================================================================
package spatial_fuser_pkg;

  localparam int HV_DIMENSION   = 2000;
  localparam int NUM_MODALITIES = 3;

  // Modality order matches the encoder's emission order: GSR, ECG, EEG.
  typedef enum logic [1:0] {
    COLLECT_GSR = 2'd0,
    COLLECT_ECG = 2'd1,
    COLLECT_EEG = 2'd2
  } modality_state_e;

endpackage
`default_nettype wire

// File: rtl/spatial_fuser_fold_majority3.sv
`default_nettype none
// ============================================================================
// Module   : fold_majority3
// Purpose  : Combinational bitwise 3-input majority over one fold slice.
// Ports    : a, b, c - input slices (WIDTH bits)
//            y       - per-bit majority of a, b, c
// Revision : 1.0 - initial release
// ============================================================================
module fold_majority3 #(
  parameter int WIDTH = 500
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule
`default_nettype wire

// File: rtl/spatial_fuser.sv
`default_nettype none
// ============================================================================
// Module   : spatial_fuser
// Purpose  : Collects folded GSR, ECG and EEG majority slices, fuses them
//            with a bitwise 3-input majority and presents one full-width
//            fused hypervector per frame over a valid/ready handshake.
// Ports    : clk, rst (async, active-low)
//            hvin_valid/hvin_ready/hvin/fold_idx - encoder slice stream
//            enc_done        - encoder frame-complete pulse (checked only)
//            fusedout_valid/fusedout_ready/fusedout - fused output
//            fold_err        - sticky fold sequencing error
//            ovf_err         - sticky dropped-slice error
// Revision : 1.0 - initial release
// ============================================================================
module spatial_fuser
  import spatial_fuser_pkg::*;
#(
  parameter int NUM_FOLDS       = 4,
  parameter int NUM_FOLDS_WIDTH = 2,
  parameter int FOLD_WIDTH      = 500,
  parameter int HV_WIDTH        = NUM_FOLDS * FOLD_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hvin_valid,
  output logic                       hvin_ready,
  input  logic [FOLD_WIDTH-1:0]      hvin,
  input  logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
  input  logic                       enc_done,
  output logic                       fusedout_valid,
  input  logic                       fusedout_ready,
  output logic [HV_WIDTH-1:0]        fusedout,
  output logic                       fold_err,
  output logic                       ovf_err
);

  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  modality_state_e              state, state_nxt;
  logic [NUM_FOLDS_WIDTH-1:0]   exp_fold, exp_fold_nxt;
  logic                         hvin_fire;
  logic                         last_fold;
  logic                         frame_done;
  logic                         frame_done_d;
  logic [FOLD_WIDTH-1:0]        gsr_buf [NUM_FOLDS];
  logic [FOLD_WIDTH-1:0]        ecg_buf [NUM_FOLDS];
  logic [FOLD_WIDTH-1:0]        out_buf [NUM_FOLDS];
  logic [FOLD_WIDTH-1:0]        fused_slice;

  // Only EEG writes touch out_buf, so only they must wait for a pending
  // output to be taken; GSR/ECG of the next frame overlap it.
  assign hvin_ready = !(state == COLLECT_EEG && fusedout_valid && !fusedout_ready);
  assign hvin_fire  = hvin_valid && hvin_ready;
  assign last_fold  = (exp_fold == LAST_FOLD);
  assign frame_done = hvin_fire && (state == COLLECT_EEG) && last_fold;

  fold_majority3 #(
    .WIDTH (FOLD_WIDTH)
  ) u_maj (
    .a (gsr_buf[exp_fold]),
    .b (ecg_buf[exp_fold]),
    .c (hvin),
    .y (fused_slice)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT_GSR;
      exp_fold <= '0;
    end else begin
      state    <= state_nxt;
      exp_fold <= exp_fold_nxt;
    end
  end

  // Next-state: slot position is always our own counter, never fold_idx.
  always_comb begin
    state_nxt    = state;
    exp_fold_nxt = exp_fold;
    if (hvin_fire) begin
      if (last_fold) begin
        exp_fold_nxt = '0;
        unique case (state)
          COLLECT_GSR: state_nxt = COLLECT_ECG;
          COLLECT_ECG: state_nxt = COLLECT_EEG;
          default:     state_nxt = COLLECT_GSR;
        endcase
      end else begin
        exp_fold_nxt = exp_fold + 1'b1;
      end
    end
  end

  // Modality buffers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_FOLDS; k++) begin
        gsr_buf[k] <= '0;
        ecg_buf[k] <= '0;
        out_buf[k] <= '0;
      end
    end else if (hvin_fire) begin
      unique case (state)
        COLLECT_GSR: gsr_buf[exp_fold] <= hvin;
        COLLECT_ECG: ecg_buf[exp_fold] <= hvin;
        default:     out_buf[exp_fold] <= fused_slice;
      endcase
    end
  end

  // Output valid and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fusedout_valid <= 1'b0;
      frame_done_d   <= 1'b0;
      fold_err       <= 1'b0;
      ovf_err        <= 1'b0;
    end else begin
      // A frame completing in the same cycle as a handshake keeps valid set.
      if (frame_done) begin
        fusedout_valid <= 1'b1;
      end else if (fusedout_ready) begin
        fusedout_valid <= 1'b0;
      end
      frame_done_d <= frame_done;
      if ((hvin_fire && (fold_idx != exp_fold)) || (enc_done && !frame_done_d)) begin
        fold_err <= 1'b1;
      end
      if (hvin_valid && !hvin_ready) begin
        ovf_err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_FOLDS; k++) begin : g_pack
    assign fusedout[k*FOLD_WIDTH +: FOLD_WIDTH] = out_buf[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_spatial_fuser.sv
`default_nettype none
// ============================================================================
// Module   : tb_spatial_fuser
// Purpose  : Self-checking bench for spatial_fuser with directed scenarios
//            and randomized frames against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spatial_fuser;

  localparam int NF = 4;
  localparam int FW = 500;
  localparam int HV = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hvin_valid;
  logic          hvin_ready;
  logic [FW-1:0] hvin;
  logic [1:0]    fold_idx;
  logic          enc_done;
  logic          fusedout_valid;
  logic          fusedout_ready;
  logic [HV-1:0] fusedout;
  logic          fold_err;
  logic          ovf_err;

  always #5 clk = ~clk;

  spatial_fuser #(
    .NUM_FOLDS       (NF),
    .NUM_FOLDS_WIDTH (2),
    .FOLD_WIDTH      (FW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hvin_valid     (hvin_valid),
    .hvin_ready     (hvin_ready),
    .hvin           (hvin),
    .fold_idx       (fold_idx),
    .enc_done       (enc_done),
    .fusedout_valid (fusedout_valid),
    .fusedout_ready (fusedout_ready),
    .fusedout       (fusedout),
    .fold_err       (fold_err),
    .ovf_err        (ovf_err)
  );

  int n_total  = 0;
  int n_bad    = 0;
  int n_xfer   = 0;
  int n_frames = 0;

  // Reference model: modality slices, fused slices and undelivered frames.
  logic [FW-1:0] m_g [NF];
  logic [FW-1:0] m_e [NF];
  logic [FW-1:0] m_o [NF];
  int            m_mod;
  int            m_fold;
  logic [HV-1:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    for (int c = 0; c < 16; c++) begin
      check($sformatf("%s[%0d]", tag, c), 128'(obs[c*125 +: 125]), 128'(exp[c*125 +: 125]));
    end
  endtask

  function automatic logic [FW-1:0] maj_ref(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                             input logic [FW-1:0] c);
    logic [FW-1:0] r;
    for (int i = 0; i < FW; i++) begin
      int s;
      s = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (s >= 2);
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] rand_slice();
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = (r << 32) | FW'($urandom);
    return r;
  endfunction

  function automatic logic [HV-1:0] m_out_vec();
    logic [HV-1:0] v;
    for (int k = 0; k < NF; k++) v[k*FW +: FW] = m_o[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NF; k++) begin
      m_g[k] = '0;
      m_e[k] = '0;
      m_o[k] = '0;
    end
    m_mod  = 0;
    m_fold = 0;
  endtask

  task automatic model_accept(input logic [FW-1:0] d, output bit fin);
    fin = 1'b0;
    case (m_mod)
      0:       m_g[m_fold] = d;
      1:       m_e[m_fold] = d;
      default: m_o[m_fold] = maj_ref(m_g[m_fold], m_e[m_fold], d);
    endcase
    if (m_fold == NF - 1) begin
      m_fold = 0;
      if (m_mod == 2) begin
        fin = 1'b1;
        n_frames++;
        exp_q.push_back(m_out_vec());
      end
      m_mod = (m_mod + 1) % 3;
    end else begin
      m_fold++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    hvin_valid = 1'b0;
    enc_done   = 1'b0;
  endtask

  task automatic send(input logic [FW-1:0] d, input int fidx);
    bit fin;
    hvin_valid = 1'b1;
    hvin       = d;
    fold_idx   = 2'(fidx);
    step();
    model_accept(d, fin);
    if (fin) enc_done = 1'b1;
  endtask

  // Every handshake must carry the oldest undelivered model frame.
  always @(negedge clk) begin
    if (rst && fusedout_valid && fusedout_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
      else check_vec("xfer", fusedout, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] ones, zeros, patt, d;
    bit            fin;
    int            gap, waited;

    ones  = '1;
    zeros = '0;
    patt  = {125{4'hA}};
    hvin_valid = 1'b0;
    hvin = '0;
    fold_idx = '0;
    enc_done = 1'b0;
    fusedout_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", fusedout_valid, 0);
    check("rst_fold_err", fold_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_ready", hvin_ready, 1);
    check_vec("rst_fused", fusedout, '0);
    rst = 1'b1;
    step();

    // Frame 1: GSR ones, ECG zeros, EEG 0xA..A -> fused equals EEG pattern
    for (int i = 0; i < 12; i++) begin
      if (i == 11) check("valid_early", fusedout_valid, 0);
      send((i < 4) ? ones : (i < 8) ? zeros : patt, i % NF);
    end
    check("valid_rise", fusedout_valid, 1);
    check_vec("f1_fused", fusedout, {NF{patt}});
    check("f1_fold_err", fold_err, 0);
    check("f1_ovf_err", ovf_err, 0);
    fusedout_ready = 1'b1;
    step();
    check("f1_valid_clear", fusedout_valid, 0);
    fusedout_ready = 1'b0;

    // Frame 2: GSR = ECG = ones, EEG zeros, downstream stalled
    for (int i = 0; i < 12; i++) send((i < 8) ? ones : zeros, i % NF);
    check_vec("f2_fused", fusedout, {HV{1'b1}});

    // 40 stalled cycles; next-frame GSR/ECG collection overlaps
    for (int c = 0; c < 40; c++) begin
      if (c < 8) begin
        d = rand_slice();
        hvin_valid = 1'b1;
        hvin = d;
        fold_idx = 2'(m_fold);
        #1;
        check("ready_overlap", hvin_ready, 1);
        step();
        model_accept(d, fin);
      end else begin
        step();
      end
      if (c % 10 == 9) check_vec("f2_stable", fusedout, {HV{1'b1}});
    end
    check("f2_valid_held", fusedout_valid, 1);

    // EEG fold 0 collides with the stall: dropped, ovf_err set
    hvin_valid = 1'b1;
    hvin = rand_slice();
    fold_idx = 2'd0;
    #1;
    check("ready_stall", hvin_ready, 0);
    step();
    check("ovf_set", ovf_err, 1);
    check_vec("f2_held", fusedout, {HV{1'b1}});

    // Handshake in the same cycle as EEG fold 0 accept
    d = rand_slice();
    hvin_valid = 1'b1;
    hvin = d;
    fold_idx = 2'd0;
    fusedout_ready = 1'b1;
    #1;
    check("ready_sim", hvin_ready, 1);
    step();
    model_accept(d, fin);
    check("valid_fall_sim", fusedout_valid, 0);
    check("xfer_count_sim", n_xfer, 2);
    check_vec("slice0_upd", fusedout, m_out_vec());
    for (int i = 1; i < NF; i++) send(rand_slice(), i);
    repeat (3) step();
    check("drain3", exp_q.size(), 0);

    // Frame 4: ECG fold 2 tagged with fold_idx 3
    for (int i = 0; i < 12; i++) begin
      if (i == 6) send(rand_slice(), 3);
      else send(rand_slice(), i % NF);
      if (i == 5) check("fold_err_before", fold_err, 0);
      if (i == 6) check("fold_err_set", fold_err, 1);
    end
    repeat (3) step();
    check("drain4", exp_q.size(), 0);

    // Reset mid-frame after six slices
    for (int i = 0; i < 6; i++) send(rand_slice(), i % NF);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", fusedout_valid, 0);
    check("mid_rst_fold_err", fold_err, 0);
    check("mid_rst_ovf_err", ovf_err, 0);
    check_vec("mid_rst_fused", fusedout, '0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized frames with random gaps and random downstream readiness
    for (int s = 0; s < 72; s++) begin
      gap = $urandom_range(0, 2);
      waited = 0;
      forever begin
        fusedout_ready = 1'($urandom_range(0, 1));
        #1;
        check("rdy_model", hvin_ready,
              !(m_mod == 2 && exp_q.size() > 0 && !fusedout_ready));
        check("vld_model", fusedout_valid, exp_q.size() > 0);
        if (gap == 0 && hvin_ready) break;
        if (gap > 0) gap--;
        step();
        waited++;
        if (waited > 40) begin
          check("slot_timeout", 0, 1);
          break;
        end
      end
      send(rand_slice(), m_fold);
    end
    fusedout_ready = 1'b1;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      step();
      waited++;
    end
    check("rand_drain", exp_q.size(), 0);
    check("xfer_total", n_xfer, n_frames);
    check("rand_fold_err", fold_err, 0);
    check("rand_ovf_err", ovf_err, 0);

    // Stray enc_done mid-stream
    enc_done = 1'b1;
    step();
    check("enc_done_stray", fold_err, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
